// File: rtl/pixel_frame_scheduler_pkg.sv
// Shared types and constants for the ping-pong pixel frame scheduler.
package pixel_frame_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } pfs_state_t;

   localparam int BANK_WORDS = 1024;
   localparam int CNT_IDX_W  = $clog2(BANK_WORDS);
   localparam int ADDR_W     = CNT_IDX_W + 1;
   localparam int DATA_W     = 32;

   localparam logic [3:0] TIMEOUT_CLASS = 4'hF;

endpackage

// File: rtl/pixel_frame_scheduler_if.sv
// Host-side pixel write handshake plus the resulting BRAM write port.
interface pixel_frame_scheduler_if;
   import pixel_frame_scheduler_pkg::*;

   logic              wr_valid;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ready;
   logic              bram_we;
   logic [ADDR_W-1:0] bram_addr;
   logic [DATA_W-1:0] bram_wdata;

   modport master (
      output wr_valid, wr_data,
      input  wr_ready, bram_we, bram_addr, bram_wdata
   );

   modport slave (
      input  wr_valid, wr_data,
      output wr_ready, bram_we, bram_addr, bram_wdata
   );

endinterface

// File: rtl/pixel_frame_scheduler_writer.sv
// Ping-pong bank writer: fill counter, active write bank and per-bank full flags.
module pixel_bank_writer
   import pixel_frame_scheduler_pkg::*;
#(
   parameter int FRAME_WORDS = 256
)
(
   input  logic                   hclk,
   input  logic                   hrst_b,
   input  logic                   abort,
   input  logic                   clr_req,
   input  logic                   clr_bank,
   pixel_frame_scheduler_if.slave wr,
   output logic [1:0]             bank_full
);

   localparam logic [CNT_IDX_W-1:0] LAST_IDX = CNT_IDX_W'(FRAME_WORDS - 1);

   logic [CNT_IDX_W-1:0] wr_cnt;
   logic                 wr_bank;
   logic                 hs;
   logic                 last_word;
   logic [1:0]           set_mask;
   logic [1:0]           clr_mask;

   assign wr.wr_ready   = !bank_full[wr_bank] && !abort;
   assign hs            = wr.wr_valid && wr.wr_ready;
   assign wr.bram_we    = hs;
   assign wr.bram_addr  = {wr_bank, wr_cnt};
   assign wr.bram_wdata = wr.wr_data;

   assign last_word = hs && (wr_cnt == LAST_IDX);
   // Writer only fills an empty bank and reader only frees a full one, so masks never overlap.
   assign set_mask  = last_word ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
   assign clr_mask  = clr_req ? (clr_bank ? 2'b10 : 2'b01) : 2'b00;

   always_ff @(posedge hclk or negedge hrst_b) begin
      if (!hrst_b) begin
         wr_cnt    <= '0;
         wr_bank   <= 1'b0;
         bank_full <= 2'b00;
      end else if (abort) begin
         wr_cnt    <= '0;
         wr_bank   <= 1'b0;
         bank_full <= 2'b00;
      end else begin
         if (last_word) begin
            wr_cnt  <= '0;
            wr_bank <= ~wr_bank;
         end else if (hs) begin
            wr_cnt  <= wr_cnt + CNT_IDX_W'(1);
         end
         bank_full <= (bank_full | set_mask) & ~clr_mask;
      end
   end

endmodule

// File: rtl/pixel_frame_scheduler.sv
// Frame scheduler: launches the SNN core on each full bank, times the run and reports results.
//   state | meaning
//   IDLE  | waiting for the read bank to become full
//   START | calca_start pulse visible, run counter cleared
//   RUN   | counting cycles until finish pulse or timeout
//   DONE  | result_valid visible, bank released, frame counted
module pixel_frame_scheduler
   import pixel_frame_scheduler_pkg::*;
#(
   parameter int FRAME_WORDS = 256,
   parameter int CNT_W       = 32
)
(
   input  logic                   hclk,
   input  logic                   hrst_b,
   pixel_frame_scheduler_if.slave wr,
   output logic                   calca_start,
   output logic                   snn_bank,
   input  logic                   one_time_finish,
   input  logic [3:0]             result_class,
   input  logic [CNT_W-1:0]       timeout_cfg,
   input  logic                   abort,
   input  logic                   intr_clr,
   output logic                   result_valid,
   output logic [3:0]             result_data,
   output logic [CNT_W-1:0]       run_cycles,
   output logic                   timeout_err,
   output logic [CNT_W-1:0]       frames_done,
   output logic [1:0]             bank_full,
   output logic                   intr
);

   pfs_state_t       state;
   logic             rd_bank;
   logic [CNT_W-1:0] run_cnt;
   logic [CNT_W-1:0] run_cnt_inc;
   logic             timeout_hit;
   logic             release_bank;

   assign run_cnt_inc  = (&run_cnt) ? run_cnt : run_cnt + CNT_W'(1);
   assign timeout_hit  = (timeout_cfg != '0) && (run_cnt == timeout_cfg - CNT_W'(1));
   assign release_bank = (state == ST_DONE) && !abort;

   pixel_bank_writer #(
      .FRAME_WORDS (FRAME_WORDS)
   ) u_writer (
      .hclk      (hclk),
      .hrst_b    (hrst_b),
      .abort     (abort),
      .clr_req   (release_bank),
      .clr_bank  (rd_bank),
      .wr        (wr),
      .bank_full (bank_full)
   );

   always_ff @(posedge hclk or negedge hrst_b) begin
      if (!hrst_b) begin
         state        <= ST_IDLE;
         rd_bank      <= 1'b0;
         run_cnt      <= '0;
         calca_start  <= 1'b0;
         snn_bank     <= 1'b0;
         result_valid <= 1'b0;
         result_data  <= 4'h0;
         run_cycles   <= '0;
         timeout_err  <= 1'b0;
         frames_done  <= '0;
         intr         <= 1'b0;
      end else begin
         calca_start  <= 1'b0;
         result_valid <= 1'b0;
         // Clear first so a DONE in the same cycle re-sets it.
         if (intr_clr) intr <= 1'b0;
         if (abort) begin
            state   <= ST_IDLE;
            rd_bank <= 1'b0;
            run_cnt <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (bank_full[rd_bank]) begin
                     state       <= ST_START;
                     calca_start <= 1'b1;
                     snn_bank    <= rd_bank;
                  end
               end
               ST_START: begin
                  run_cnt <= '0;
                  state   <= ST_RUN;
               end
               ST_RUN: begin
                  run_cnt <= run_cnt_inc;
                  if (one_time_finish) begin
                     result_data  <= result_class;
                     timeout_err  <= 1'b0;
                     result_valid <= 1'b1;
                     state        <= ST_DONE;
                  end else if (timeout_hit) begin
                     result_data  <= TIMEOUT_CLASS;
                     timeout_err  <= 1'b1;
                     result_valid <= 1'b1;
                     state        <= ST_DONE;
                  end
               end
               ST_DONE: begin
                  run_cycles  <= run_cnt;
                  rd_bank     <= ~rd_bank;
                  frames_done <= frames_done + CNT_W'(1);
                  intr        <= 1'b1;
                  state       <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pixel_frame_scheduler.sv
// Directed scenarios plus random traffic against a frame-level reference model.
module tb_pixel_frame_scheduler;
   import pixel_frame_scheduler_pkg::*;

   localparam int FW = 256;
   localparam int CW = 32;

   logic          hclk = 1'b0;
   logic          hrst_b = 1'b0;
   logic          calca_start, snn_bank, one_time_finish, abort, intr_clr;
   logic          result_valid, timeout_err, intr;
   logic [3:0]    result_class, result_data;
   logic [CW-1:0] timeout_cfg, run_cycles, frames_done;
   logic [1:0]    bank_full;

   always #5 hclk = ~hclk;

   pixel_frame_scheduler_if wr_if ();

   pixel_frame_scheduler #(.FRAME_WORDS(FW), .CNT_W(CW)) dut (
      .hclk            (hclk),
      .hrst_b          (hrst_b),
      .wr              (wr_if.slave),
      .calca_start     (calca_start),
      .snn_bank        (snn_bank),
      .one_time_finish (one_time_finish),
      .result_class    (result_class),
      .timeout_cfg     (timeout_cfg),
      .abort           (abort),
      .intr_clr        (intr_clr),
      .result_valid    (result_valid),
      .result_data     (result_data),
      .run_cycles      (run_cycles),
      .timeout_err     (timeout_err),
      .frames_done     (frames_done),
      .bank_full       (bank_full),
      .intr            (intr)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // Frame-level reference: words accepted, frames released, pipeline phase.
   int            m_acc, m_rel, m_k, m_rc_pend;
   bit            m_idle, m_run, m_cs, m_rv, m_to, m_intr, m_snn;
   logic [3:0]    m_rd;
   logic [CW-1:0] m_rc, m_fd;

   always @(negedge hclk) begin
      int         w, full_n;
      bit         exp_rdy, exp_we, nx_cs, nx_rv, nx_idle;
      logic [1:0] exp_full;
      if (!hrst_b) begin
         m_acc = 0; m_rel = 0; m_k = 0; m_rc_pend = 0;
         m_idle = 1; m_run = 0; m_cs = 0; m_rv = 0; m_to = 0; m_intr = 0; m_snn = 0;
         m_rd = 4'h0; m_rc = '0; m_fd = '0;
      end
      w        = m_acc / FW;
      full_n   = w - m_rel;
      exp_full = (full_n == 0) ? 2'b00 : (full_n == 1) ? (2'b01 << (m_rel % 2)) : 2'b11;
      exp_rdy  = (full_n != 2) && !abort;
      exp_we   = wr_if.wr_valid && exp_rdy;
      chk("wr_ready", wr_if.wr_ready, exp_rdy);
      chk("bram_we", wr_if.bram_we, exp_we);
      if (exp_we) begin
         chk("bram_addr", wr_if.bram_addr, (w % 2) * BANK_WORDS + (m_acc % FW));
         chk("bram_wdata", wr_if.bram_wdata, wr_if.wr_data);
      end
      chk("bank_full", bank_full, exp_full);
      chk("calca_start", calca_start, m_cs);
      chk("snn_bank", snn_bank, m_snn);
      chk("result_valid", result_valid, m_rv);
      chk("result_data", result_data, m_rd);
      chk("timeout_err", timeout_err, m_to);
      chk("run_cycles", run_cycles, m_rc);
      chk("frames_done", frames_done, m_fd);
      chk("intr", intr, m_intr);
      if (hrst_b) begin
         nx_cs = 0; nx_rv = 0; nx_idle = m_idle;
         if (abort) begin
            m_acc = 0; m_rel = 0; m_run = 0; nx_idle = 1;
            if (intr_clr) m_intr = 0;
         end else begin
            if (m_rv) begin
               m_rel++; m_fd++; m_rc = CW'(m_rc_pend); m_intr = 1; nx_idle = 1;
            end else if (intr_clr) begin
               m_intr = 0;
            end
            if (m_idle && full_n >= 1) begin
               nx_cs = 1; m_snn = ((m_rel % 2) == 1); nx_idle = 0;
            end
            if (m_cs) begin
               m_run = 1; m_k = 0;
            end else if (m_run) begin
               m_k++;
               if (one_time_finish) begin
                  m_rd = result_class; m_to = 0; m_rc_pend = m_k; m_run = 0; nx_rv = 1;
               end else if (timeout_cfg != 0 && CW'(m_k) == timeout_cfg) begin
                  m_rd = 4'hF; m_to = 1; m_rc_pend = m_k; m_run = 0; nx_rv = 1;
               end
            end
            if (exp_we) m_acc++;
         end
         m_cs = nx_cs; m_rv = nx_rv; m_idle = nx_idle;
      end
   end

   task automatic tick();
      @(posedge hclk);
      #1;
   endtask

   task automatic do_reset();
      hrst_b = 1'b0;
      wr_if.wr_valid = 1'b0; one_time_finish = 1'b0; abort = 1'b0; intr_clr = 1'b0;
      repeat (2) tick();
      hrst_b = 1'b1;
      tick();
   endtask

   task automatic push_words(input int n);
      int guard;
      wr_if.wr_valid = 1'b1;
      for (int i = 0; i < n; i++) begin
         wr_if.wr_data = $urandom;
         guard = 0;
         while (!wr_if.wr_ready && guard < 2000) begin
            tick();
            guard++;
         end
         if (guard >= 2000) begin
            chk("push_wait", 1'b0, 1'b1);
            break;
         end
         tick();
      end
      wr_if.wr_valid = 1'b0;
   endtask

   task automatic wait_for(input string tag, input bit want_rv, input int max, output int cyc);
      cyc = 0;
      do begin
         tick();
         cyc++;
      end while (!(want_rv ? result_valid : calca_start) && cyc < max);
      chk(tag, want_rv ? result_valid : calca_start, 1'b1);
   endtask

   initial begin
      int cyc;
      wr_if.wr_valid = 1'b0; wr_if.wr_data = '0;
      one_time_finish = 1'b0; result_class = 4'h0; timeout_cfg = '0;
      abort = 1'b0; intr_clr = 1'b0;
      repeat (3) tick();
      chk("rst_calca", calca_start, 1'b0);
      chk("rst_rv", result_valid, 1'b0);
      chk("rst_full", bank_full, 2'b00);
      chk("rst_frames", frames_done, 0);
      chk("rst_intr", intr, 1'b0);
      chk("rst_addr", wr_if.bram_addr, 0);
      hrst_b = 1'b1;
      tick();

      // single frame, finish after 100 RUN cycles
      wr_if.wr_valid = 1'b1;
      for (int i = 0; i < FW; i++) begin
         wr_if.wr_data = $urandom;
         #1;
         chk("t1_addr", wr_if.bram_addr, i);
         tick();
      end
      wr_if.wr_valid = 1'b0;
      chk("t1_full", bank_full, 2'b01);
      chk("t1_cs_early", calca_start, 1'b0);
      tick();
      chk("t1_cs", calca_start, 1'b1);
      chk("t1_snn", snn_bank, 1'b0);
      tick();
      chk("t1_cs_once", calca_start, 1'b0);
      repeat (99) tick();
      result_class = 4'h7; one_time_finish = 1'b1;
      tick();
      one_time_finish = 1'b0;
      chk("t1_rv", result_valid, 1'b1);
      chk("t1_class", result_data, 4'h7);
      tick();
      chk("t1_cycles", run_cycles, 100);
      chk("t1_intr", intr, 1'b1);
      chk("t1_free", bank_full, 2'b00);
      chk("t1_frames", frames_done, 1);

      // two frames back to back, bank 1 waits for bank 0 to finish
      do_reset();
      wr_if.wr_valid = 1'b1;
      for (int i = 0; i < 2 * FW; i++) begin
         wr_if.wr_data = $urandom;
         #1;
         chk("t2_addr", wr_if.bram_addr, (i < FW) ? i : BANK_WORDS + i - FW);
         tick();
      end
      chk("t2_both", bank_full, 2'b11);
      #1;
      chk("t2_stall", wr_if.wr_ready, 1'b0);
      chk("t2_no_we", wr_if.bram_we, 1'b0);
      wr_if.wr_valid = 1'b0;
      chk("t2_snn0", snn_bank, 1'b0);
      result_class = 4'h3; one_time_finish = 1'b1;
      tick();
      one_time_finish = 1'b0;
      chk("t2_class0", result_data, 4'h3);
      tick();
      chk("t2_release", bank_full, 2'b10);
      wait_for("t2_start1", 1'b0, 10, cyc);
      chk("t2_start_lat", cyc, 1);
      chk("t2_snn1", snn_bank, 1'b1);
      repeat (20) tick();
      result_class = 4'hC; one_time_finish = 1'b1;
      tick();
      one_time_finish = 1'b0;
      chk("t2_class1", result_data, 4'hC);
      tick();
      chk("t2_free", bank_full, 2'b00);
      chk("t2_frames", frames_done, 2);

      // timeout after 50 RUN cycles
      do_reset();
      timeout_cfg = 50;
      push_words(FW);
      wait_for("t3_start", 1'b0, 10, cyc);
      wait_for("t3_rv", 1'b1, 200, cyc);
      chk("t3_latency", cyc, 51);
      chk("t3_class", result_data, 4'hF);
      chk("t3_terr", timeout_err, 1'b1);
      tick();
      chk("t3_cycles", run_cycles, 50);
      chk("t3_frames", frames_done, 1);

      // intr_clr colliding with DONE
      intr_clr = 1'b1;
      tick();
      intr_clr = 1'b0;
      chk("t4_clr", intr, 1'b0);
      push_words(FW);
      wait_for("t4_start", 1'b0, 10, cyc);
      wait_for("t4_rv", 1'b1, 200, cyc);
      intr_clr = 1'b1;
      tick();
      chk("t4_set_wins", intr, 1'b1);
      tick();
      chk("t4_clr_alone", intr, 1'b0);
      intr_clr = 1'b0;

      // abort mid-RUN then a late finish
      timeout_cfg = 0;
      push_words(FW);
      wait_for("t5_start", 1'b0, 10, cyc);
      repeat (10) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t5_full", bank_full, 2'b00);
      result_class = 4'h5; one_time_finish = 1'b1;
      tick();
      one_time_finish = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("t5_no_rv", result_valid, 1'b0);
         chk("t5_no_cs", calca_start, 1'b0);
         tick();
      end
      chk("t5_frames", frames_done, 2);
      chk("t5_kept", result_data, 4'hF);
      wr_if.wr_valid = 1'b1;
      #1;
      chk("t5_addr0", wr_if.bram_addr, 0);
      wr_if.wr_valid = 1'b0;

      // reset in the middle of a frame
      push_words(37);
      hrst_b = 1'b0;
      #1;
      chk("t6_full", bank_full, 2'b00);
      chk("t6_frames", frames_done, 0);
      chk("t6_intr", intr, 1'b0);
      chk("t6_addr", wr_if.bram_addr, 0);
      chk("t6_data", result_data, 4'h0);
      chk("t6_cycles", run_cycles, 0);
      tick();
      hrst_b = 1'b1;
      tick();
      wr_if.wr_valid = 1'b1;
      #1;
      chk("t6_addr_new", wr_if.bram_addr, 0);
      tick();
      wr_if.wr_valid = 1'b0;

      // random traffic, model-checked every cycle
      for (int seg = 0; seg < 4; seg++) begin
         timeout_cfg = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(20, 90);
         for (int i = 0; i < 1000; i++) begin
            wr_if.wr_valid  = ($urandom_range(0, 9) < 7);
            wr_if.wr_data   = $urandom;
            one_time_finish = ($urandom_range(0, 39) == 0);
            result_class    = 4'($urandom);
            abort           = ($urandom_range(0, 499) == 0);
            intr_clr        = ($urandom_range(0, 7) == 0);
            tick();
         end
      end
      wr_if.wr_valid = 1'b0; one_time_finish = 1'b0; abort = 1'b0; intr_clr = 1'b0;
      repeat (3) tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_chk);
      $fatal(1);
   end

endmodule
